vrf_bank_arbiter: RTL and testbench
===================================

# vrf_bank_arbiter

Per-bank request arbiter and sequencer for the lane vector register file. It sits between the lane's operand requesters (read ports feeding operand queues, write ports from functional-unit results) and the NrBank single-port VRF SRAM banks. Each cycle it grants at most one access per bank, drives the bank request, address, write-enable, data and strobe buses, and routes each bank's one-cycle-latency read data back to the read port that issued it.

## Interface
- NrBank, 4: number of single-port VRF banks; power of two, ≥2
- NrReadPort, 4: read requesters
- NrWritePort, 2: write requesters
- AddrWidth, 6: word address width inside a bank
- DataWidth, 64: bank word width; strobe width is DataWidth/8
- MaxWriteStreak, 3: consecutive write grants to one bank while a read waits there, after which the read wins
- BankW: derived, $clog2(NrBank)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- rd_valid_i  in  NrReadPort  read request valid, one per port
- rd_ready_o  out  NrReadPort  read request granted this cycle
- rd_bank_i  in  NrReadPort×BankW  target bank
- rd_addr_i  in  NrReadPort×AddrWidth  word address in bank
- rd_resp_valid_o  out  NrReadPort  read data valid, one cycle after grant
- rd_resp_data_o  out  NrReadPort×DataWidth  read data
- wr_valid_i  in  NrWritePort  write request valid
- wr_ready_o  out  NrWritePort  write request granted this cycle
- wr_bank_i  in  NrWritePort×BankW  target bank
- wr_addr_i  in  NrWritePort×AddrWidth  word address
- wr_data_i  in  NrWritePort×DataWidth  write data
- wr_strb_i  in  NrWritePort×(DataWidth/8)  byte enables
- bank_req_o  out  NrBank  bank access strobe
- bank_addr_o  out  NrBank×AddrWidth  bank address
- bank_wen_o  out  NrBank  1 = write
- bank_wdata_o  out  NrBank×DataWidth  write data
- bank_wstrb_o  out  NrBank×(DataWidth/8)  byte enables
- bank_rdata_i  in  NrBank×DataWidth  bank read data, valid one cycle after a read request

## Operation
- Valid/ready handshake. Requester holds valid and payload stable until ready. Ready is combinational from the current valids and arbiter state; transfer happens when valid && ready.
- Per-bank arbitration is independent. Each bank picks one winner from requests whose bank field matches.
- Priority per bank: writes beat reads, except when the bank's write-streak counter equals MaxWriteStreak and a read is pending there. Then the read wins.
- Write-streak counter, one per bank, saturating 0..MaxWriteStreak:
  - +1 on a write grant while a read to that bank is pending but not granted.
  - Cleared on any read grant, or on a cycle with no pending read to that bank.
- Among writes: round-robin per bank with a pointer of width $clog2(NrWritePort). Among reads: round-robin per bank with a pointer of width $clog2(NrReadPort).
  - Search starts at the pointer. On a grant, the pointer moves to winner+1 mod N; otherwise it holds.
- A port targets one bank per cycle, so it gets at most one grant.
- Bank outputs:
  - On a grant: bank_req_o=1; addr/wdata/wstrb come from the winner; bank_wen_o=1 for a write.
  - With no grant: bank_req_o=0 and bank_wen_o=0. Address and data are don't-care, driven 0.
- Response pipeline: a registered record per read port (valid, bank index) is captured on the grant. The next cycle, rd_resp_valid_o[p]=1 and rd_resp_data_o[p]=bank_rdata_i[stored bank]. When not valid, data is driven 0.
- There is no response backpressure. Requesters must accept data in that cycle.

## Timing
- Grant and bank drive are combinational in the request cycle (cycle 0). Read data appears at rd_resp_* in cycle 1. Write completes at the cycle-0 edge.
- Back-to-back: a port may be granted every cycle. Its responses then appear every cycle in order.
- Simultaneous read and write to the same bank/address: only one is granted, so there is no read-during-write case at a bank.
- Reset (async assert): all pointers, streak counters and response-valid registers go to 0. While rst_ni=0, every rd_ready_o, wr_ready_o, bank_req_o and bank_wen_o is forced to 0. First grant is possible in the first cycle after deassertion.
- Reset mid-operation drops in-flight responses: rd_resp_valid_o=0 immediately and stays 0 in the cycle after release.

## Test plan
- Single read, port 1 to bank 2, addr 5:
  - Cycle 0: rd_ready_o=0010, bank_req_o=0100, bank_addr_o[2]=5, bank_wen_o=0.
  - Cycle 1: rd_resp_valid_o=0010 with bank 2's data.
- Read ports 0–3 all valid to bank 0 for 8 cycles: grant order 0,1,2,3,0,1,2,3; responses one cycle later in the same order.
- Four reads to banks 0,1,2,3 in one cycle: all four rd_ready_o=1, bank_req_o=1111; each response comes from the matching bank next cycle.
- Starvation guard: write port 0 always valid to bank 1, read port 2 always valid to bank 1.
  - Grants: W, W, W, R, W, W, W, R…
  - The streak counter saturates at 3, and the read returns data one cycle after its grant.
- Write strobes: write port 1 to bank 3, addr 9, data 0xDEAD_BEEF, strobe 0x0F.
  - bank_wen_o[3]=1, bank_wstrb_o[3]=0x0F.
  - A later read returns 0xDEAD_BEEF in the low 4 bytes.
- Assert rst_ni low while a read is granted: rd_resp_valid_o stays 0 and pointers return to 0. After release, port 0 wins first in a full contention.

Source files
------------

// File: rtl/vrf_bank_arbiter.sv
// Per-bank request arbiter for the lane vector register file.
// Each bank independently grants one read or write per cycle. Writes win by
// default. A per-bank write-streak counter hands the bank to a waiting read
// after MaxWriteStreak consecutive writes. Read data returns one cycle after
// the grant through a registered (valid, bank) record kept for each read port.
module vrf_bank_arbiter #(
   parameter int unsigned NrBank         = 4,
   parameter int unsigned NrReadPort     = 4,
   parameter int unsigned NrWritePort    = 2,
   parameter int unsigned AddrWidth      = 6,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned MaxWriteStreak = 3,
   parameter int unsigned BankW          = $clog2(NrBank)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NrReadPort-1:0]                rd_valid_i,
   output logic [NrReadPort-1:0]                rd_ready_o,
   input  logic [NrReadPort*BankW-1:0]          rd_bank_i,
   input  logic [NrReadPort*AddrWidth-1:0]      rd_addr_i,
   output logic [NrReadPort-1:0]                rd_resp_valid_o,
   output logic [NrReadPort*DataWidth-1:0]      rd_resp_data_o,
   input  logic [NrWritePort-1:0]               wr_valid_i,
   output logic [NrWritePort-1:0]               wr_ready_o,
   input  logic [NrWritePort*BankW-1:0]         wr_bank_i,
   input  logic [NrWritePort*AddrWidth-1:0]     wr_addr_i,
   input  logic [NrWritePort*DataWidth-1:0]     wr_data_i,
   input  logic [NrWritePort*(DataWidth/8)-1:0] wr_strb_i,
   output logic [NrBank-1:0]                    bank_req_o,
   output logic [NrBank*AddrWidth-1:0]          bank_addr_o,
   output logic [NrBank-1:0]                    bank_wen_o,
   output logic [NrBank*DataWidth-1:0]          bank_wdata_o,
   output logic [NrBank*(DataWidth/8)-1:0]      bank_wstrb_o,
   input  logic [NrBank*DataWidth-1:0]          bank_rdata_i
);

   localparam int unsigned StrbW   = DataWidth / 8;
   localparam int unsigned RdPtrW  = (NrReadPort > 1) ? $clog2(NrReadPort) : 1;
   localparam int unsigned WrPtrW  = (NrWritePort > 1) ? $clog2(NrWritePort) : 1;
   localparam int unsigned StreakW = $clog2(MaxWriteStreak + 1);

   logic [NrReadPort-1:0]  rd_hit [NrBank];
   logic [NrWritePort-1:0] wr_hit [NrBank];

   logic [RdPtrW-1:0]  rd_ptr_q [NrBank];
   logic [RdPtrW-1:0]  rd_ptr_d [NrBank];
   logic [WrPtrW-1:0]  wr_ptr_q [NrBank];
   logic [WrPtrW-1:0]  wr_ptr_d [NrBank];
   logic [StreakW-1:0] streak_q [NrBank];
   logic [StreakW-1:0] streak_d [NrBank];

   logic [NrBank-1:0] rd_found, wr_found, read_win, write_win;
   logic [RdPtrW-1:0] rd_idx [NrBank];
   logic [WrPtrW-1:0] wr_idx [NrBank];

   logic [NrReadPort-1:0] resp_valid_q;
   logic [BankW-1:0]      resp_bank_q [NrReadPort];

   // Decode which requesters target each bank
   always_comb begin
      for (int unsigned b = 0; b < NrBank; b++) begin
         rd_hit[b] = '0;
         wr_hit[b] = '0;
         for (int unsigned p = 0; p < NrReadPort; p++)
            rd_hit[b][p] = rd_valid_i[p] && (rd_bank_i[p*BankW +: BankW] == BankW'(b));
         for (int unsigned p = 0; p < NrWritePort; p++)
            wr_hit[b][p] = wr_valid_i[p] && (wr_bank_i[p*BankW +: BankW] == BankW'(b));
      end
   end

   // Per-bank round-robin pick, write/read priority and bank drive
   always_comb begin
      logic [RdPtrW-1:0] ri;
      logic [WrPtrW-1:0] wi;
      ri           = '0;
      wi           = '0;
      rd_ready_o   = '0;
      wr_ready_o   = '0;
      bank_req_o   = '0;
      bank_wen_o   = '0;
      bank_addr_o  = '0;
      bank_wdata_o = '0;
      bank_wstrb_o = '0;
      for (int unsigned b = 0; b < NrBank; b++) begin
         rd_found[b] = 1'b0;
         rd_idx[b]   = '0;
         wr_found[b] = 1'b0;
         wr_idx[b]   = '0;
         for (int unsigned k = 0; k < NrReadPort; k++) begin
            ri = RdPtrW'((32'(rd_ptr_q[b]) + k) % NrReadPort);
            if (!rd_found[b] && rd_hit[b][ri]) begin
               rd_found[b] = 1'b1;
               rd_idx[b]   = ri;
            end
         end
         for (int unsigned k = 0; k < NrWritePort; k++) begin
            wi = WrPtrW'((32'(wr_ptr_q[b]) + k) % NrWritePort);
            if (!wr_found[b] && wr_hit[b][wi]) begin
               wr_found[b] = 1'b1;
               wr_idx[b]   = wi;
            end
         end
         // Grants are suppressed while reset is held
         read_win[b]  = rst_ni && rd_found[b] &&
                        (!wr_found[b] || (streak_q[b] == StreakW'(MaxWriteStreak)));
         write_win[b] = rst_ni && wr_found[b] && !read_win[b];
         if (read_win[b]) begin
            rd_ready_o[rd_idx[b]]                  = 1'b1;
            bank_req_o[b]                          = 1'b1;
            bank_addr_o[b*AddrWidth +: AddrWidth]  = rd_addr_i[rd_idx[b]*AddrWidth +: AddrWidth];
         end else if (write_win[b]) begin
            wr_ready_o[wr_idx[b]]                  = 1'b1;
            bank_req_o[b]                          = 1'b1;
            bank_wen_o[b]                          = 1'b1;
            bank_addr_o[b*AddrWidth +: AddrWidth]  = wr_addr_i[wr_idx[b]*AddrWidth +: AddrWidth];
            bank_wdata_o[b*DataWidth +: DataWidth] = wr_data_i[wr_idx[b]*DataWidth +: DataWidth];
            bank_wstrb_o[b*StrbW +: StrbW]         = wr_strb_i[wr_idx[b]*StrbW +: StrbW];
         end
      end
   end

   // Next pointers and write-streak counters
   always_comb begin
      for (int unsigned b = 0; b < NrBank; b++) begin
         rd_ptr_d[b] = rd_ptr_q[b];
         wr_ptr_d[b] = wr_ptr_q[b];
         streak_d[b] = streak_q[b];
         if (read_win[b])
            rd_ptr_d[b] = (rd_idx[b] == RdPtrW'(NrReadPort - 1)) ? '0 : rd_idx[b] + 1'b1;
         if (write_win[b])
            wr_ptr_d[b] = (wr_idx[b] == WrPtrW'(NrWritePort - 1)) ? '0 : wr_idx[b] + 1'b1;
         if (read_win[b] || !rd_found[b])
            streak_d[b] = '0;
         else if (write_win[b] && (streak_q[b] != StreakW'(MaxWriteStreak)))
            streak_d[b] = streak_q[b] + 1'b1;
      end
   end

   // Arbitration state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned b = 0; b < NrBank; b++) begin
            rd_ptr_q[b] <= '0;
            wr_ptr_q[b] <= '0;
            streak_q[b] <= '0;
         end
      end else begin
         for (int unsigned b = 0; b < NrBank; b++) begin
            rd_ptr_q[b] <= rd_ptr_d[b];
            wr_ptr_q[b] <= wr_ptr_d[b];
            streak_q[b] <= streak_d[b];
         end
      end
   end

   // Capture each read grant's bank for the next-cycle response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_valid_q <= '0;
         for (int unsigned p = 0; p < NrReadPort; p++)
            resp_bank_q[p] <= '0;
      end else begin
         resp_valid_q <= rd_ready_o;
         for (int unsigned p = 0; p < NrReadPort; p++)
            if (rd_ready_o[p])
               resp_bank_q[p] <= rd_bank_i[p*BankW +: BankW];
      end
   end

   // Route bank read data back to the issuing read port
   always_comb begin
      rd_resp_valid_o = resp_valid_q;
      rd_resp_data_o  = '0;
      for (int unsigned p = 0; p < NrReadPort; p++)
         if (resp_valid_q[p])
            rd_resp_data_o[p*DataWidth +: DataWidth] =
               bank_rdata_i[resp_bank_q[p]*DataWidth +: DataWidth];
   end

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// Directed bench for vrf_bank_arbiter with a behavioural model of the four
// single-port SRAM banks (one-cycle read latency, byte-strobed writes).
module tb_vrf_bank_arbiter;

   logic         clk, rst_n;
   logic [3:0]   rd_valid, rd_ready, rd_resp_valid;
   logic [7:0]   rd_bank;
   logic [23:0]  rd_addr;
   logic [255:0] rd_resp_data;
   logic [1:0]   wr_valid, wr_ready;
   logic [3:0]   wr_bank;
   logic [11:0]  wr_addr;
   logic [127:0] wr_data;
   logic [15:0]  wr_strb;
   logic [3:0]   bank_req, bank_wen;
   logic [23:0]  bank_addr;
   logic [255:0] bank_wdata;
   logic [31:0]  bank_wstrb;
   logic [255:0] bank_rdata;

   int n_cmp = 0;
   int n_err = 0;

   vrf_bank_arbiter #(
      .NrBank(4), .NrReadPort(4), .NrWritePort(2),
      .AddrWidth(6), .DataWidth(64), .MaxWriteStreak(3)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .rd_valid_i(rd_valid), .rd_ready_o(rd_ready),
      .rd_bank_i(rd_bank), .rd_addr_i(rd_addr),
      .rd_resp_valid_o(rd_resp_valid), .rd_resp_data_o(rd_resp_data),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .wr_bank_i(wr_bank), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .wr_strb_i(wr_strb),
      .bank_req_o(bank_req), .bank_addr_o(bank_addr), .bank_wen_o(bank_wen),
      .bank_wdata_o(bank_wdata), .bank_wstrb_o(bank_wstrb),
      .bank_rdata_i(bank_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pat(input int unsigned b, input int unsigned a);
      return 64'hC0DE_0000_0000_0000 | (64'(b) << 8) | 64'(a);
   endfunction

   // SRAM bank model
   logic [63:0] mem [4][64];
   logic [63:0] rdata_q [4];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 4; b++) begin
            rdata_q[b] <= '0;
            for (int a = 0; a < 64; a++) mem[b][a] <= pat(b, a);
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (bank_req[b]) begin
               if (bank_wen[b]) begin
                  for (int i = 0; i < 8; i++)
                     if (bank_wstrb[b*8+i])
                        mem[b][bank_addr[b*6 +: 6]][i*8 +: 8] <= bank_wdata[b*64 + i*8 +: 8];
               end else begin
                  rdata_q[b] <= mem[b][bank_addr[b*6 +: 6]];
               end
            end
         end
      end
   end

   always_comb begin
      bank_rdata = '0;
      for (int b = 0; b < 4; b++) bank_rdata[b*64 +: 64] = rdata_q[b];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_req(input int unsigned p, input logic v, input int unsigned b, input int unsigned a);
      rd_valid[p]       = v;
      rd_bank[p*2 +: 2] = 2'(b);
      rd_addr[p*6 +: 6] = 6'(a);
   endtask

   task automatic wr_req(input int unsigned p, input logic v, input int unsigned b,
                         input int unsigned a, input logic [63:0] d, input logic [7:0] s);
      wr_valid[p]        = v;
      wr_bank[p*2 +: 2]  = 2'(b);
      wr_addr[p*6 +: 6]  = 6'(a);
      wr_data[p*64 +: 64] = d;
      wr_strb[p*8 +: 8]  = s;
   endtask

   task automatic idle();
      rd_valid = '0; rd_bank = '0; rd_addr = '0;
      wr_valid = '0; wr_bank = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      // Requests during reset must not be granted
      for (int p = 0; p < 4; p++) rd_req(p, 1'b1, 0, p);
      wr_req(0, 1'b1, 1, 0, 64'h1, 8'hFF);
      @(negedge clk);
      chk("rst_rd_ready", rd_ready, 4'b0000);
      chk("rst_wr_ready", wr_ready, 2'b00);
      chk("rst_bank_req", bank_req, 4'b0000);
      chk("rst_bank_wen", bank_wen, 4'b0000);
      chk("rst_resp_valid", rd_resp_valid, 4'b0000);
      step();
      rst_n = 1'b1;
      idle();
      @(negedge clk);
      chk("idle_bank_req", bank_req, 4'b0000);

      // Single read: port 1 -> bank 2, addr 5
      step();
      rd_req(1, 1'b1, 2, 5);
      @(negedge clk);
      chk("single_ready", rd_ready, 4'b0010);
      chk("single_bank_req", bank_req, 4'b0100);
      chk("single_addr", bank_addr[2*6 +: 6], 6'd5);
      chk("single_wen", bank_wen, 4'b0000);
      step();
      idle();
      @(negedge clk);
      chk("single_resp_valid", rd_resp_valid, 4'b0010);
      chk("single_resp_data", rd_resp_data[1*64 +: 64], pat(2, 5));

      // Full read contention on bank 0 for eight cycles
      step();
      for (int p = 0; p < 4; p++) rd_req(p, 1'b1, 0, p);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rr_grant", rd_ready, 4'b0001 << (i % 4));
         if (i > 0) begin
            chk("rr_resp_valid", rd_resp_valid, 4'b0001 << ((i - 1) % 4));
            chk("rr_resp_data", rd_resp_data[((i - 1) % 4)*64 +: 64], pat(0, (i - 1) % 4));
         end
         step();
      end
      idle();
      @(negedge clk);
      chk("rr_last_valid", rd_resp_valid, 4'b1000);
      chk("rr_last_data", rd_resp_data[3*64 +: 64], pat(0, 3));

      // Four reads to four different banks in one cycle
      step();
      for (int p = 0; p < 4; p++) rd_req(p, 1'b1, p, 10 + p);
      @(negedge clk);
      chk("par_ready", rd_ready, 4'b1111);
      chk("par_bank_req", bank_req, 4'b1111);
      step();
      idle();
      @(negedge clk);
      chk("par_resp_valid", rd_resp_valid, 4'b1111);
      for (int p = 0; p < 4; p++)
         chk("par_resp_data", rd_resp_data[p*64 +: 64], pat(p, 10 + p));

      // Starvation guard: write port 0 and read port 2 both on bank 1
      step();
      wr_req(0, 1'b1, 1, 7, 64'h1111_2222_3333_4444, 8'hFF);
      rd_req(2, 1'b1, 1, 7);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("streak_wr", wr_ready, (i % 4 == 3) ? 2'b00 : 2'b01);
         chk("streak_rd", rd_ready, (i % 4 == 3) ? 4'b0100 : 4'b0000);
         if (i > 0) chk("streak_resp_valid", rd_resp_valid, (i == 4) ? 4'b0100 : 4'b0000);
         if (i == 4) chk("streak_resp_data", rd_resp_data[2*64 +: 64], 64'h1111_2222_3333_4444);
         step();
      end
      idle();
      @(negedge clk);
      chk("streak_resp2_valid", rd_resp_valid, 4'b0100);
      chk("streak_resp2_data", rd_resp_data[2*64 +: 64], 64'h1111_2222_3333_4444);

      // Strobed write: port 1 -> bank 3, addr 9, low four bytes only
      step();
      wr_req(1, 1'b1, 3, 9, 64'h0000_0000_DEAD_BEEF, 8'h0F);
      @(negedge clk);
      chk("wstrb_ready", wr_ready, 2'b10);
      chk("wstrb_req", bank_req, 4'b1000);
      chk("wstrb_wen", bank_wen, 4'b1000);
      chk("wstrb_addr", bank_addr[3*6 +: 6], 6'd9);
      chk("wstrb_strb", bank_wstrb[3*8 +: 8], 8'h0F);
      chk("wstrb_data", bank_wdata[3*64 +: 64], 64'h0000_0000_DEAD_BEEF);
      step();
      idle();
      rd_req(0, 1'b1, 3, 9);
      @(negedge clk);
      chk("wstrb_rd_ready", rd_ready, 4'b0001);
      chk("wstrb_rd_wen", bank_wen, 4'b0000);
      step();
      idle();
      @(negedge clk);
      chk("wstrb_rd_valid", rd_resp_valid, 4'b0001);
      chk("wstrb_rd_data", rd_resp_data[0*64 +: 64], 64'hC0DE_0000_DEAD_BEEF);

      // Reset during operation; bank 0 read pointer is 1 at this point
      step();
      for (int p = 0; p < 4; p++) rd_req(p, 1'b1, 0, p);
      @(negedge clk);
      chk("mid_grant_a", rd_ready, 4'b0010);
      step();
      @(negedge clk);
      chk("mid_resp_valid", rd_resp_valid, 4'b0010);
      chk("mid_resp_data", rd_resp_data[1*64 +: 64], pat(0, 1));
      chk("mid_grant_b", rd_ready, 4'b0100);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_resp_valid", rd_resp_valid, 4'b0000);
      chk("mid_rst_ready", rd_ready, 4'b0000);
      chk("mid_rst_bank_req", bank_req, 4'b0000);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_grant", rd_ready, 4'b0001);
      chk("post_rst_resp_valid", rd_resp_valid, 4'b0000);
      step();
      @(negedge clk);
      chk("post_rst_resp2_valid", rd_resp_valid, 4'b0001);
      chk("post_rst_resp2_data", rd_resp_data[0*64 +: 64], pat(0, 0));
      chk("post_rst_grant2", rd_ready, 4'b0010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
